// File: rtl/de3d_tc_mc_rd.sv
// Texture-cache MC read side: streams one stored line back out of the lo/hi RAM pair in beat order.
// Optional macro TC_MC_RD_CRIT_EN: start at rd_beat (critical beat first) and wrap modulo BEATS.

module de3d_tc_mc_rd #(
  parameter int unsigned LINE_W = 6,
  parameter int unsigned BEATS  = 4,
  parameter int unsigned DATA_W = 128
) (
  input  logic                            mclock,
  input  logic                            rst,
  input  logic                            rd_req,
  input  logic [LINE_W-1:0]               rd_line,
  input  logic                            rd_ram_sel,
  input  logic [$clog2(BEATS)-1:0]        rd_beat,
  output logic                            rd_ack,
  output logic                            rd_busy,
  output logic                            ram_ren_lo,
  output logic                            ram_ren_hi,
  output logic [LINE_W+$clog2(BEATS)-2:0] ram_addr,
  input  logic [DATA_W-1:0]               ram_dout_lo,
  input  logic [DATA_W-1:0]               ram_dout_hi,
  output logic [DATA_W-1:0]               rd_data,
  output logic                            rd_valid,
  output logic                            rd_last,
  input  logic                            rd_stall
);

  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned ADDR_W = LINE_W + BEAT_W - 1;
  localparam int unsigned FULL_W = LINE_W + BEAT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic [LINE_W-1:0]   line_q;
  logic                sel_q;
  logic [BEAT_W-1:0]   b_q;
  logic [BEAT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                bank_q;

  logic                p_v_q;
  logic                p_bank_q;
  logic                p_last_q;

  logic                skid_v_q;
  logic                skid_last_q;
  logic [DATA_W-1:0]   skid_data_q;

  logic                rd_valid_q;
  logic                rd_last_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic                ack_c;
  logic                issue_c;
  logic                last_issue_c;
  logic                accept_last_c;
  logic                out_free_c;
  logic [BEAT_W-1:0]   b_d;
  logic [BEAT_W-1:0]   b0_c;
  logic [DATA_W-1:0]   mux_c;

  // Both RAMs hold beat pairs, so the shared address drops the bank bit of the beat index.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [LINE_W-1:0] line,
                                                input logic [BEAT_W-1:0] beat);
    logic [FULL_W-1:0] full;
    full = {line, beat};
    return ADDR_W'(full >> 1);
  endfunction

`ifdef TC_MC_RD_CRIT_EN
  assign b0_c = rd_beat;
`else
  logic unused_rd_beat_c;
  assign unused_rd_beat_c = ^rd_beat;
  assign b0_c = '0;
`endif

  assign ack_c         = rd_req & (state_q == ST_IDLE);
  assign issue_c       = (state_q == ST_READ) & ~rd_stall & ~skid_v_q;
  assign last_issue_c  = (cnt_q == BEAT_W'(BEATS - 1));
  assign b_d           = b_q + BEAT_W'(1);
  assign accept_last_c = rd_valid_q & rd_last_q & ~rd_stall;
  assign out_free_c    = ~rd_valid_q | ~rd_stall;
  assign mux_c         = p_bank_q ? ram_dout_hi : ram_dout_lo;

  // Line sequencer: address and bank of the next beat are precomputed so an issue only gates the enable.
  always_ff @(posedge mclock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      sel_q   <= 1'b0;
      b_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      bank_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ack_c) begin
            line_q  <= rd_line;
            sel_q   <= rd_ram_sel;
            b_q     <= b0_c;
            cnt_q   <= '0;
            addr_q  <= addr_of(rd_line, b0_c);
            bank_q  <= b0_c[0] ^ rd_ram_sel;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue_c) begin
            b_q    <= b_d;
            cnt_q  <= cnt_q + BEAT_W'(1);
            addr_q <= addr_of(line_q, b_d);
            bank_q <= b_d[0] ^ sel_q;
            if (last_issue_c) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (accept_last_c) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Return path: bank tag rides with the read, then output register with a one-entry skid behind it.
  always_ff @(posedge mclock or posedge rst) begin
    if (rst) begin
      p_v_q       <= 1'b0;
      p_bank_q    <= 1'b0;
      p_last_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      p_v_q    <= issue_c;
      p_bank_q <= bank_q;
      p_last_q <= issue_c & last_issue_c;
      if (out_free_c) begin
        if (skid_v_q) begin
          rd_data_q  <= skid_data_q;
          rd_last_q  <= skid_last_q;
          rd_valid_q <= 1'b1;
          skid_v_q   <= 1'b0;
        end else begin
          rd_valid_q <= p_v_q;
          rd_last_q  <= p_v_q & p_last_q;
          if (p_v_q) begin
            rd_data_q <= mux_c;
          end
        end
      end else if (p_v_q) begin
        // Issues stop while the skid is occupied, so it is always empty here.
        skid_data_q <= mux_c;
        skid_last_q <= p_last_q;
        skid_v_q    <= 1'b1;
      end
    end
  end

  assign rd_ack     = ack_c;
  assign rd_busy    = (state_q != ST_IDLE);
  assign ram_ren_lo = issue_c & ~bank_q;
  assign ram_ren_hi = issue_c & bank_q;
  assign ram_addr   = addr_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;

endmodule

// File: tb/tb_de3d_tc_mc_rd.sv
// Bench for de3d_tc_mc_rd: a sync RAM pair model plus a per-line beat list built from the
// bank/address/order rules, compared against the RAM port and the output stream every cycle.

module tb_de3d_tc_mc_rd;

  localparam int unsigned LINE_W = 6;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned ADDR_W = LINE_W + BEAT_W - 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic                mclock = 1'b0;
  logic                rst;
  logic                rd_req;
  logic [LINE_W-1:0]   rd_line;
  logic                rd_ram_sel;
  logic [BEAT_W-1:0]   rd_beat;
  logic                rd_ack;
  logic                rd_busy;
  logic                ram_ren_lo;
  logic                ram_ren_hi;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_dout_lo = '0;
  logic [DATA_W-1:0]   ram_dout_hi = '0;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                rd_last;
  logic                rd_stall;

  de3d_tc_mc_rd #(.LINE_W(LINE_W), .BEATS(BEATS), .DATA_W(DATA_W)) dut (
    .mclock      (mclock),
    .rst         (rst),
    .rd_req      (rd_req),
    .rd_line     (rd_line),
    .rd_ram_sel  (rd_ram_sel),
    .rd_beat     (rd_beat),
    .rd_ack      (rd_ack),
    .rd_busy     (rd_busy),
    .ram_ren_lo  (ram_ren_lo),
    .ram_ren_hi  (ram_ren_hi),
    .ram_addr    (ram_addr),
    .ram_dout_lo (ram_dout_lo),
    .ram_dout_hi (ram_dout_hi),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last),
    .rd_stall    (rd_stall)
  );

  always #5 mclock = ~mclock;

  logic [DATA_W-1:0] lo_mem [0:DEPTH-1];
  logic [DATA_W-1:0] hi_mem [0:DEPTH-1];

  // Synchronous RAM pair, one cycle read latency.
  always @(posedge mclock) begin
    if (ram_ren_lo) ram_dout_lo <= lo_mem[ram_addr];
    if (ram_ren_hi) ram_dout_hi <= hi_mem[ram_addr];
  end

  typedef struct { logic bank; logic [ADDR_W-1:0] addr; } iss_t;
  typedef struct { logic [DATA_W-1:0] data; logic last; } out_t;

  iss_t iss_q[$];
  out_t out_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ack_cyc = 0;
  int   last_cyc = 0;
  int   popped = 0;
  int   stall_left = 0;
  bit   act = 1'b0;
  bit   acked_now = 1'b0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Expected issue and output lists for the request currently on the inputs.
  task automatic push_line();
    int   b0;
    int   b;
    int   bank;
    int   a;
    iss_t i;
    out_t o;
`ifdef TC_MC_RD_CRIT_EN
    b0 = int'(rd_beat);
`else
    b0 = 0;
`endif
    for (int k = 0; k < BEATS; k++) begin
      b      = (b0 + k) % BEATS;
      bank   = (b % 2) ^ int'(rd_ram_sel);
      a      = int'(rd_line) * (BEATS / 2) + b / 2;
      i.bank = bank[0];
      i.addr = ADDR_W'(a);
      o.data = (bank != 0) ? hi_mem[a] : lo_mem[a];
      o.last = (k == BEATS - 1);
      iss_q.push_back(i);
      out_q.push_back(o);
    end
  endtask

  // One clock: check at the falling edge, advance the model, return 1 time unit after the rising edge.
  task automatic step();
    bit clr;
    @(negedge mclock);
    cyc++;
    clr = 1'b0;
    check("ack", DATA_W'(rd_ack), DATA_W'(rd_req & ~act));
    check("busy", DATA_W'(rd_busy), DATA_W'(act));
    if (ram_ren_lo | ram_ren_hi) begin
      check("ren_onehot", DATA_W'(ram_ren_lo & ram_ren_hi), '0);
      check("ren_in_stall", DATA_W'(rd_stall), '0);
      if (iss_q.size() == 0) begin
        check("extra_issue", DATA_W'(ram_ren_lo | ram_ren_hi), '0);
      end else begin
        check("bank", DATA_W'(ram_ren_hi), DATA_W'(iss_q[0].bank));
        check("addr", DATA_W'(ram_addr), DATA_W'(iss_q[0].addr));
        void'(iss_q.pop_front());
      end
    end
    if (rd_valid) begin
      if (out_q.size() == 0) begin
        check("extra_beat", DATA_W'(rd_valid), '0);
      end else begin
        check("data", rd_data, out_q[0].data);
        check("last", DATA_W'(rd_last), DATA_W'(out_q[0].last));
        if (!rd_stall) begin
          if (out_q[0].last) begin
            clr      = 1'b1;
            last_cyc = cyc;
          end
          void'(out_q.pop_front());
          popped++;
        end
      end
    end
    acked_now = rd_req & ~act;
    if (acked_now) begin
      push_line();
      act     = 1'b1;
      ack_cyc = cyc;
      popped  = 0;
    end
    if (clr) act = 1'b0;
    @(posedge mclock);
    #1;
  endtask

  // mode 0: no stall, 1: random stall, 2: three stall cycles while the 2nd beat is presented.
  task automatic run_line(input int line, input int sel, input int beat, input int mode);
    rd_line    = LINE_W'(line);
    rd_ram_sel = sel[0];
    rd_beat    = BEAT_W'(beat);
    rd_req     = 1'b1;
    rd_stall   = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    acked_now  = 1'b0;
    stall_left = 3;
    for (int g = 0; g < 20 && !acked_now; g++) step();
    if (!acked_now) check("ack_timeout", DATA_W'(acked_now), DATA_W'(1));
    rd_req = 1'b0;
    for (int g = 0; g < 200 && act; g++) begin
      case (mode)
        1:       rd_stall = ($urandom_range(0, 3) == 0);
        2:       rd_stall = (popped == 1) && rd_valid && (stall_left > 0);
        default: rd_stall = 1'b0;
      endcase
      if (mode == 2 && rd_stall) stall_left--;
      step();
      if (mode == 2 && rd_stall && stall_left == 0)
        check("stall_unissued", DATA_W'(iss_q.size()), DATA_W'(BEATS - 3));
    end
    if (act) check("drain_timeout", DATA_W'(act), '0);
    if (mode == 0) check("line_cycles", DATA_W'(last_cyc - ack_cyc), DATA_W'(BEATS + 2));
    rd_stall = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      lo_mem[a] = {$urandom, $urandom, $urandom, $urandom};
      hi_mem[a] = {$urandom, $urandom, $urandom, $urandom};
    end
    rst = 1'b1; rd_req = 1'b0; rd_stall = 1'b0;
    rd_line = '0; rd_ram_sel = 1'b0; rd_beat = '0;
    repeat (2) @(posedge mclock);
    #1;
    check("rst_valid", DATA_W'(rd_valid), '0);
    check("rst_last", DATA_W'(rd_last), '0);
    check("rst_busy", DATA_W'(rd_busy), '0);
    check("rst_ren", DATA_W'({ram_ren_hi, ram_ren_lo}), '0);
    check("rst_addr", DATA_W'(ram_addr), '0);
    check("rst_data", rd_data, '0);
    rst = 1'b0;
    repeat (2) step();

    // Directed lines: sel 0 and 1, then the held-stall case.
    run_line(5, 0, 0, 0);
    run_line(5, 1, 0, 0);
    run_line(5, 0, 0, 2);

    // Requests held high across lines: ack only in the cycle after the previous line completes.
    begin
      int acks = 0;
      rd_req = 1'b1;
      rd_line = LINE_W'($urandom); rd_ram_sel = 1'($urandom); rd_beat = BEAT_W'($urandom);
      for (int g = 0; g < 300 && acks < 3; g++) begin
        rd_stall = ($urandom_range(0, 4) == 0);
        step();
        if (acked_now) begin
          if (acks > 0) check("b2b_gap", DATA_W'(cyc - last_cyc), DATA_W'(1));
          acks++;
          rd_line = LINE_W'($urandom); rd_ram_sel = 1'($urandom); rd_beat = BEAT_W'($urandom);
          if (acks == 3) rd_req = 1'b0;
        end
      end
      rd_req = 1'b0;
      rd_stall = 1'b0;
      for (int g = 0; g < 200 && act; g++) step();
      check("b2b_done", DATA_W'(act), '0);
    end

    // Reset during the second issue of a line.
    rd_line = LINE_W'(17); rd_ram_sel = 1'b1; rd_beat = '0; rd_req = 1'b1;
    acked_now = 1'b0;
    for (int g = 0; g < 20 && !acked_now; g++) step();
    rd_req = 1'b0;
    for (int g = 0; g < 20 && iss_q.size() > BEATS - 1; g++) step();
    check("second_issue", DATA_W'(ram_ren_lo | ram_ren_hi), DATA_W'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_ren", DATA_W'({ram_ren_hi, ram_ren_lo}), '0);
    check("mid_rst_addr", DATA_W'(ram_addr), '0);
    check("mid_rst_valid", DATA_W'(rd_valid), '0);
    check("mid_rst_last", DATA_W'(rd_last), '0);
    check("mid_rst_busy", DATA_W'(rd_busy), '0);
    check("mid_rst_data", rd_data, '0);
    iss_q.delete();
    out_q.delete();
    act = 1'b0;
    repeat (2) @(posedge mclock);
    #1;
    rst = 1'b0;
    repeat (4) step();
    run_line(17, 1, 0, 0);

    // Critical-beat-first ordering (plain order when the feature is compiled out).
    run_line(33, 0, 3, 0);
    run_line(12, 1, 1, 2);

    // Random lines with random backpressure and idle gaps.
    for (int n = 0; n < 20; n++) begin
      run_line(int'($urandom_range(0, (1 << LINE_W) - 1)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, BEATS - 1)), int'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
